// File: rtl/mem_pkg.sv
// Shared definitions for the Memory-stage data memory and the stall logic
// that watches it: FSM state encoding, access-type constants, defaults.
package mem_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_ADDR_W    = 11;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SECOND = 2'd2
    } mem_state_e;

    localparam logic ACC_READ   = 1'b0;
    localparam logic ACC_WRITE  = 1'b1;
    localparam logic ACC_SINGLE = 1'b0;
    localparam logic ACC_DOUBLE = 1'b1;

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the Memory stage and the data memory.
// The master side presents requests, the slave side answers with busy/read data.
interface data_memory_unit_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 11
);
    logic                   req_valid;
    logic                   req_write;
    logic                   req_dbl;
    logic [ADDR_W-1:0]      addr;
    logic [2*WORD_SIZE-1:0] wdata;
    logic                   busy;
    logic                   rd_valid;
    logic [2*WORD_SIZE-1:0] rdata;

    modport master (
        output req_valid, req_write, req_dbl, addr, wdata,
        input  busy, rd_valid, rdata
    );

    modport slave (
        input  req_valid, req_write, req_dbl, addr, wdata,
        output busy, rd_valid, rdata
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read.
// No reset: contents are zeroed by the owning controller.
module mem_array #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 11
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] o_rdata
);
    logic [WORD_SIZE-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/data_memory_unit.sv
// Memory-stage data memory: sequential clear after reset, single/double
// word accesses and a busy stall flag for the hazard unit.
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_unit_if.slave  bus
);
    localparam int W = WORD_SIZE;

    mem_state_e        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [W-1:0]      r_wlo;
    logic              r_write;
    logic [W-1:0]      r_hi;
    logic              r_rd_pend;
    logic              r_dbl_pend;
    logic              r_rd_valid;
    logic [2*W-1:0]    r_rdata;

    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [W-1:0]      w_wdata;
    logic [W-1:0]      w_dout;

    mem_array #(
        .WORD_SIZE (W),
        .ADDR_W    (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_dout)
    );

    // RAM port mux; rst blocks any write so an aborted double leaves no trace
    always_comb begin
        w_we    = 1'b0;
        w_addr  = bus.addr;
        w_wdata = '0;
        unique case (r_state)
            ST_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_clr_ptr;
            end
            ST_IDLE: begin
                w_we    = bus.req_valid && (bus.req_write == ACC_WRITE);
                w_wdata = (bus.req_dbl == ACC_DOUBLE) ? bus.wdata[2*W-1:W]
                                                      : bus.wdata[W-1:0];
            end
            ST_SECOND: begin
                w_we    = (r_write == ACC_WRITE);
                w_addr  = r_addr + ADDR_W'(1);
                w_wdata = r_wlo;
            end
            default: ;
        endcase
        if (rst) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_addr     <= '0;
            r_wlo      <= '0;
            r_write    <= 1'b0;
            r_hi       <= '0;
            r_rd_pend  <= 1'b0;
            r_dbl_pend <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_dbl_pend <= 1'b0;
            if (r_rd_pend) begin
                r_rdata    <= {{W{1'b0}}, w_dout};
                r_rd_valid <= 1'b1;
            end
            if (r_dbl_pend) begin
                r_rdata    <= {r_hi, w_dout};
                r_rd_valid <= 1'b1;
            end
            unique case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == '1) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_dbl == ACC_DOUBLE) begin
                            r_addr  <= bus.addr;
                            r_wlo   <= bus.wdata[W-1:0];
                            r_write <= bus.req_write;
                            r_state <= ST_SECOND;
                        end else if (bus.req_write == ACC_READ) begin
                            r_rd_pend <= 1'b1;
                        end
                    end
                end
                ST_SECOND: begin
                    // RAM output now holds the first word of the pair
                    if (r_write == ACC_READ) begin
                        r_hi       <= w_dout;
                        r_dbl_pend <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.rd_valid = r_rd_valid;
    assign bus.rdata    = r_rdata;
endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit (ADDR_W=4, WORD_SIZE=16)
// against a word-array reference model.
module tb_data_memory_unit;
    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_unit_if #(.WORD_SIZE(W), .ADDR_W(AW)) bus ();

    data_memory_unit #(.WORD_SIZE(W), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] model [DEPTH];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int nxt(input int a);
        return (a + 1) % DEPTH;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_dbl   = 1'($urandom_range(0, 1));
        bus.addr      = AW'($urandom_range(0, DEPTH - 1));
        bus.wdata     = $urandom;
    endtask

    task automatic drive(input logic wr, input logic dbl,
                         input int a, input logic [2*W-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_dbl   = dbl;
        bus.addr      = AW'(a);
        bus.wdata     = d;
    endtask

    task automatic wr_single(input int a, input logic [W-1:0] d);
        drive(1'b1, 1'b0, a, {W'($urandom), d});
        tick;
        idle_bus;
        model[a] = d;
    endtask

    task automatic rd_single(input int a, output logic v,
                             output logic [2*W-1:0] d);
        drive(1'b0, 1'b0, a, $urandom);
        tick;
        idle_bus;
        tick;
        v = bus.rd_valid;
        d = bus.rdata;
    endtask

    task automatic wr_double(input int a, input logic [2*W-1:0] d,
                             output logic b1, output logic b2);
        drive(1'b1, 1'b1, a, d);
        tick;
        b1 = bus.busy;
        idle_bus;
        tick;
        b2 = bus.busy;
        model[a]      = d[2*W-1:W];
        model[nxt(a)] = d[W-1:0];
    endtask

    task automatic rd_double(input int a, output logic b1, output logic v,
                             output logic [2*W-1:0] d);
        drive(1'b0, 1'b1, a, $urandom);
        tick;
        b1 = bus.busy;
        idle_bus;
        tick;
        tick;
        v = bus.rd_valid;
        d = bus.rdata;
    endtask

    task automatic apply_reset(input int hold, output int cnt);
        rst = 1'b1;
        idle_bus;
        repeat (hold) tick;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            tick;
        end
    endtask

    task automatic test_reset;
        int cnt;
        logic v;
        logic [2*W-1:0] d;
        apply_reset(2, cnt);
        n_tests++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL reset_busy_len got=%0d want=16", cnt);
        end
        for (int i = 0; i < DEPTH; i++) wr_single(i, W'($urandom_range(1, 16'hFFFF)));
        rd_single(4, v, d);
        rst = 1'b1;
        idle_bus;
        tick;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b rdv=%b rdata=%h want 1/0/0",
                     bus.busy, bus.rd_valid, bus.rdata);
        end
        rst = 1'b0;
        apply_reset(5, cnt);
        n_tests++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL reset_held_busy_len got=%0d want=16", cnt);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_single(i, v, d);
            n_tests++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_clear@%0d got v=%b d=%h want 1/0", i, v, d);
            end
        end
    endtask

    task automatic test_single;
        logic v;
        logic [2*W-1:0] d;
        wr_single(5, 16'hBEEF);
        rd_single(5, v, d);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL single_beef got v=%b d=%h want 1/0000beef", v, d);
        end
        for (int k = 0; k < 20; k++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            wr_single(a, W'($urandom));
            rd_single(a, v, d);
            n_tests++;
            if (v !== 1'b1 || d !== {16'h0, model[a]}) begin
                n_fail++;
                $display("FAIL single_rand@%0d got v=%b d=%h want %h", a, v, d,
                         {16'h0, model[a]});
            end
        end
    endtask

    task automatic test_double(input int a, input logic [2*W-1:0] val);
        logic b1, b2, v;
        logic [2*W-1:0] d;
        wr_double(a, val, b1, b2);
        n_tests++;
        if (b1 !== 1'b1 || b2 !== 1'b0) begin
            n_fail++;
            $display("FAIL dbl_wr_busy@%0d got %b%b want 10", a, b1, b2);
        end
        rd_single(a, v, d);
        n_tests++;
        if (d !== {16'h0, val[31:16]}) begin
            n_fail++;
            $display("FAIL dbl_hi@%0d got %h want %h", a, d, {16'h0, val[31:16]});
        end
        rd_single(nxt(a), v, d);
        n_tests++;
        if (d !== {16'h0, val[15:0]}) begin
            n_fail++;
            $display("FAIL dbl_lo@%0d got %h want %h", nxt(a), d, {16'h0, val[15:0]});
        end
        rd_double(a, b1, v, d);
        n_tests++;
        if (b1 !== 1'b1 || v !== 1'b1 || d !== val) begin
            n_fail++;
            $display("FAIL dbl_rd@%0d got b=%b v=%b d=%h want 1/1/%h", a, b1, v, d, val);
        end
    endtask

    task automatic test_busy_drop;
        logic b1, v;
        logic [2*W-1:0] d;
        wr_single(3, 16'h2222);
        drive(1'b1, 1'b1, 12, 32'hCAFED00D);
        tick;
        model[12] = 16'hCAFE;
        model[13] = 16'hD00D;
        drive(1'b1, 1'b0, 3, 32'h00001111);
        tick;
        idle_bus;
        rd_single(3, v, d);
        n_tests++;
        if (d !== 32'h00002222) begin
            n_fail++;
            $display("FAIL busy_drop got %h want 00002222", d);
        end
        drive(1'b1, 1'b0, 3, 32'h00001111);
        tick;
        idle_bus;
        model[3] = 16'h1111;
        rd_single(3, v, d);
        n_tests++;
        if (d !== 32'h00001111) begin
            n_fail++;
            $display("FAIL busy_retry got %h want 00001111", d);
        end
        rd_double(12, b1, v, d);
        n_tests++;
        if (d !== {model[12], model[13]}) begin
            n_fail++;
            $display("FAIL busy_dbl got %h want %h", d, {model[12], model[13]});
        end
    endtask

    task automatic test_reset_mid_double;
        int cnt;
        logic v;
        logic [2*W-1:0] d;
        wr_single(10, 16'h7777);
        drive(1'b1, 1'b1, 9, 32'h9999ABCD);
        tick;
        rst = 1'b1;
        idle_bus;
        tick;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            tick;
        end
        n_tests++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL mid_dbl_busy_len got=%0d want=16", cnt);
        end
        rd_single(9, v, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_dbl_m9 got %h want 0", d);
        end
        rd_single(10, v, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_dbl_m10 got %h want 0", d);
        end
    endtask

    task automatic test_back_to_back;
        int addrs [8];
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] val;
            addrs[i] = $urandom_range(0, DEPTH - 1);
            val = W'($urandom);
            drive(1'b1, 1'b0, addrs[i], {16'hFFFF, val});
            tick;
            model[addrs[i]] = val;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, addrs[i], $urandom);
            tick;
            if (i > 0) begin
                n_tests++;
                if (bus.rd_valid !== 1'b1 || bus.rdata !== {16'h0, model[addrs[i-1]]}) begin
                    n_fail++;
                    $display("FAIL b2b_rd%0d got v=%b d=%h want %h", i - 1,
                             bus.rd_valid, bus.rdata, {16'h0, model[addrs[i-1]]});
                end
            end
        end
        idle_bus;
        tick;
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.rdata !== {16'h0, model[addrs[7]]}) begin
            n_fail++;
            $display("FAIL b2b_rd7 got v=%b d=%h want %h", bus.rd_valid, bus.rdata,
                     {16'h0, model[addrs[7]]});
        end
        tick;
        n_tests++;
        if (bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse got rdv=%b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_random;
        logic b1, b2, v;
        logic [2*W-1:0] d;
        for (int k = 0; k < 120; k++) begin
            int a, op;
            a  = $urandom_range(0, DEPTH - 1);
            op = $urandom_range(0, 3);
            case (op)
                0: wr_single(a, W'($urandom));
                1: wr_double(a, $urandom, b1, b2);
                2: begin
                    rd_single(a, v, d);
                    n_tests++;
                    if (v !== 1'b1 || d !== {16'h0, model[a]}) begin
                        n_fail++;
                        $display("FAIL rand_rd@%0d got v=%b d=%h want %h", a, v, d,
                                 {16'h0, model[a]});
                    end
                end
                default: begin
                    rd_double(a, b1, v, d);
                    n_tests++;
                    if (v !== 1'b1 || d !== {model[a], model[nxt(a)]}) begin
                        n_fail++;
                        $display("FAIL rand_dbl@%0d got v=%b d=%h want %h", a, v, d,
                                 {model[a], model[nxt(a)]});
                    end
                end
            endcase
            if ($urandom_range(0, 3) == 0) tick;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_bus;
        test_reset;
        test_single;
        test_double(7, 32'h12345678);
        test_double(15, 32'hAAAA5555);
        test_busy_drop;
        test_back_to_back;
        test_random;
        test_reset_mid_double;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised single-port data memory for the Memory stage of the five-stage pipeline. It adds three things over a plain word RAM: sequential clear-on-reset driven by a counter, one- or two-word (double) accesses for 32-bit PC/flag push/pop, and a `busy` stall handshake back to the hazard unit. A double access takes two cycles, and the address wraps modulo the depth.

## Interface
Parameters:
- `WORD_SIZE`, 16: bits per memory word.
- `ADDR_W`, 11: address width; depth = 2**ADDR_W words.

Ports (clock and reset first; **reset `rst`, synchronous, active-high; clock `clk`**):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset; starts the clear sequence.
- `req_valid`  in  1  access request this cycle.
- `req_write`  in  1  1 = write, 0 = read; sampled with `req_valid`.
- `req_dbl`  in  1  1 = two-word access at `addr`, `addr+1`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  2*WORD_SIZE  write data; single write uses the low word only.
- `busy`  out  1  unit cannot accept a request (clearing or mid-double).
- `rd_valid`  out  1  one-cycle pulse: `rdata` updated this cycle.
- `rdata`  out  2*WORD_SIZE  read data; held until the next read completes.

## Operation
- States:
  - CLEAR: zero memory, one word per cycle.
  - IDLE: accept requests.
  - SECOND: second word of a double access.
- `busy` = (state != IDLE), decoded from the state register.
- Reset, in any state: state←CLEAR, `clr_ptr`←0, `rd_valid`←0, `rdata`←0, latched request cleared. Any in-flight access is aborted; its second word is not written or read.
- CLEAR:
  - each cycle writes mem[`clr_ptr`]←0, then `clr_ptr`++.
  - after writing address 2**ADDR_W−1, goes to IDLE.
  - requests are ignored.
- IDLE, with `req_valid`=1 (accepted):
  - Single write: mem[addr]←wdata[WORD_SIZE−1:0]. Stay IDLE.
  - Single read: next cycle `rdata`←{0, mem[addr]}, `rd_valid`=1. Stay IDLE.
  - Double: latch `addr`, `wdata`, `req_write`; go to SECOND.
    - First cycle: write stores mem[addr]←wdata[2W−1:W] (high word first); read fetches mem[addr] into the high half.
- SECOND:
  - Address = latched addr+1 mod 2**ADDR_W (wraps 2**ADDR_W−1 → 0).
  - Write stores the low word. Read places mem[addr+1] into the low half.
  - Then back to IDLE.
  - A double read pulses `rd_valid` on the cycle after SECOND, with the full 2W-bit word.
- Requests presented while `busy`=1 are dropped. The requester holds them until `busy`=0.
- `req_write`, `req_dbl`, `addr` and `wdata` are don't-care when `req_valid`=0.

## Timing
- Reset to ready: `busy`=1 from the cycle after `rst` is sampled, for exactly 2**ADDR_W cycles once `rst` drops. `rst` held high keeps `clr_ptr` at 0.
- Single read latency: 1 cycle (request at edge N, `rd_valid`/`rdata` valid after edge N+1).
- Double read latency: 2 cycles. `busy`=1 for 1 cycle.
- Writes complete at the accepting edge. A read of the same address on the next cycle returns the new data.
- Throughput:
  - singles: 1 per cycle, back-to-back.
  - doubles: 1 per 2 cycles.
- All outputs are registered.
- `rst` in SECOND: the second word is not written; memory is cleared anyway.

## Structure
- Shared package `mem_pkg`: state encoding (CLEAR/IDLE/SECOND), access-type constants, default `WORD_SIZE`/`ADDR_W`. The pipeline-side stall logic reuses these.
- Sub-module `mem_array`: single-port synchronous RAM.
  - One write-enable, registered read, parameters `WORD_SIZE` and `ADDR_W`.
  - No reset inside; clearing is done by the controller FSM.
- Top level holds the FSM, `clr_ptr`, the request latch, address-increment/wrap logic and `rdata` assembly.

## Test plan
(ADDR_W=4, WORD_SIZE=16 unless stated)
1. Reset clear: pulse `rst` over dirty memory → `busy`=1 for 16 cycles, then 0; reading addresses 0..15 returns 0.
2. Single write/read: write `0xBEEF`@5, read @5 next cycle → `rd_valid` one cycle later, `rdata`=`0x0000BEEF`.
3. Double write/read: double write `0x12345678`@7 → mem[7]=`0x1234`, mem[8]=`0x5678`, `busy`=1 one cycle. Double read @7 → `rdata`=`0x12345678` after 2 cycles.
4. Wrap-around: double write `0xAAAA5555`@15 → mem[15]=`0xAAAA`, mem[0]=`0x5555`. Double read @15 returns the same value.
5. Request while busy: single write `0x1111`@3 issued during SECOND → dropped, mem[3] unchanged. The same request re-presented in IDLE is accepted.
6. Reset mid-double: `rst` asserted in SECOND of a write @9 → mem[10] is not written, full clear follows, and after `busy` falls mem[9]=mem[10]=0.
